// File: rtl/seg_pkg.sv
// Shared segment-register types and widths for the segment register port logic.
package seg_pkg;
  typedef enum logic [1:0] {SEG_ES = 2'd0, SEG_CS = 2'd1, SEG_SS = 2'd2, SEG_DS = 2'd3} seg_t;
  localparam int SEG_W      = 2;
  localparam int SEG_DATA_W = 16;
endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first masked requester at or after ptr wins.
module rr_arbiter #(
  parameter int N  = 3,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [N-1:0]  mask_to,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [PW-1:0] next_ptr
);
  logic          found;
  logic [PW-1:0] idx;

  always_comb begin
    gnt      = '0;
    next_ptr = ptr;
    found    = 1'b0;
    idx      = '0;
    for (int k = 0; k < N; k++) begin
      idx = PW'((int'(ptr) + k) % N);
      if (!found && req[idx] && mask_to[idx]) begin
        gnt[idx] = 1'b1;
        next_ptr = PW'((int'(idx) + 1) % N);
        found    = 1'b1;
      end
    end
  end
endmodule

// File: rtl/seg_reg_port_arbiter.sv
// Shares the segment register file read port (round-robin + lock) and write port
// (fixed priority) among EU, BIU and debug; flags CS writes for prefetch flush.
module seg_reg_port_arbiter
  import seg_pkg::*;
#(
  parameter int NUM_RD = 3,
  parameter int NUM_WR = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_RD-1:0]            rd_req,
  input  logic [NUM_RD-1:0]            rd_lock,
  input  logic [SEG_W*NUM_RD-1:0]      rd_seg,
  output logic [NUM_RD-1:0]            rd_gnt,
  output logic [NUM_RD-1:0]            rd_valid,
  output logic [SEG_DATA_W-1:0]        rd_data,
  input  logic [NUM_WR-1:0]            wr_req,
  input  logic [SEG_W*NUM_WR-1:0]      wr_seg,
  input  logic [SEG_DATA_W*NUM_WR-1:0] wr_data,
  output logic [NUM_WR-1:0]            wr_gnt,
  output logic [SEG_W-1:0]             rf_rd_sel,
  input  logic [SEG_DATA_W-1:0]        rf_rd_val,
  output logic                         rf_wr_en,
  output logic [SEG_W-1:0]             rf_wr_sel,
  output logic [SEG_DATA_W-1:0]        rf_wr_val,
  output logic                         cs_changed
);
  localparam int PW = (NUM_RD > 1) ? $clog2(NUM_RD) : 1;

  logic [PW-1:0]     rr_ptr, next_ptr, gnt_idx, lock_owner;
  logic              lock_vld;
  logic [NUM_RD-1:0] rd_mask, arb_gnt;

  // A held lock only narrows the field while its owner is still asking.
  always_comb begin
    rd_mask = '1;
    if (lock_vld && rd_req[lock_owner]) begin
      rd_mask             = '0;
      rd_mask[lock_owner] = 1'b1;
    end
  end

  rr_arbiter #(.N(NUM_RD), .PW(PW)) u_rd_arb (
    .req      (rd_req),
    .mask_to  (rd_mask),
    .ptr      (rr_ptr),
    .gnt      (arb_gnt),
    .next_ptr (next_ptr)
  );

  always_comb begin
    rd_gnt    = reset ? '0 : arb_gnt;
    rf_rd_sel = '0;
    gnt_idx   = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      if (rd_gnt[i]) begin
        rf_rd_sel = rd_seg[SEG_W*i +: SEG_W];
        gnt_idx   = PW'(i);
      end
    end
  end

  assign rd_data = rf_rd_val;

  // Descending scan so the lowest requesting index is the one left standing.
  always_comb begin
    wr_gnt    = '0;
    rf_wr_en  = 1'b0;
    rf_wr_sel = '0;
    rf_wr_val = '0;
    for (int i = NUM_WR - 1; i >= 0; i--) begin
      if (wr_req[i] && !reset) begin
        wr_gnt    = '0;
        wr_gnt[i] = 1'b1;
        rf_wr_en  = 1'b1;
        rf_wr_sel = wr_seg[SEG_W*i +: SEG_W];
        rf_wr_val = wr_data[SEG_DATA_W*i +: SEG_DATA_W];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr     <= '0;
      lock_vld   <= 1'b0;
      lock_owner <= '0;
      rd_valid   <= '0;
      cs_changed <= 1'b0;
    end else begin
      rd_valid   <= rd_gnt;
      cs_changed <= rf_wr_en && (rf_wr_sel == SEG_CS);
      // With no grant nobody (owner included) requested, so the lock drops.
      lock_vld   <= (|rd_gnt) && rd_lock[gnt_idx];
      if (|rd_gnt) begin
        rr_ptr     <= next_ptr;
        lock_owner <= gnt_idx;
      end
    end
  end
endmodule

// File: tb/tb_seg_reg_port_arbiter.sv
// Bench for seg_reg_port_arbiter: directed vector table, lock/reset sequences, random traffic vs model.
module tb_seg_reg_port_arbiter;
  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  rd_req, rd_lock, rd_gnt, rd_valid;
  logic [5:0]  rd_seg;
  logic [15:0] rd_data, rf_rd_val, rf_wr_val;
  logic [1:0]  wr_req, wr_gnt, rf_rd_sel, rf_wr_sel;
  logic [3:0]  wr_seg;
  logic [31:0] wr_data;
  logic        rf_wr_en, cs_changed;

  seg_reg_port_arbiter #(.NUM_RD(3), .NUM_WR(2)) dut (
    .clk(clk), .reset(reset), .rd_req(rd_req), .rd_lock(rd_lock), .rd_seg(rd_seg),
    .rd_gnt(rd_gnt), .rd_valid(rd_valid), .rd_data(rd_data), .wr_req(wr_req),
    .wr_seg(wr_seg), .wr_data(wr_data), .wr_gnt(wr_gnt), .rf_rd_sel(rf_rd_sel),
    .rf_rd_val(rf_rd_val), .rf_wr_en(rf_wr_en), .rf_wr_sel(rf_wr_sel),
    .rf_wr_val(rf_wr_val), .cs_changed(cs_changed)
  );

  always #5 clk = ~clk;

  // Register file: registered read with write-to-read bypass.
  logic [15:0] rf_mem [4];
  always @(posedge clk) begin
    if (rf_wr_en) rf_mem[rf_wr_sel] <= rf_wr_val;
    rf_rd_val <= (rf_wr_en && rf_wr_sel == rf_rd_sel) ? rf_wr_val : rf_mem[rf_rd_sel];
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model state
  int          m_ptr = 0;
  int          m_lock = -1;
  logic [15:0] shadow [4];
  logic [2:0]  exp_vld;
  logic [15:0] exp_data;
  logic        exp_cs;

  // Called at posedge+1 with inputs applied; returns at the next posedge+1.
  task automatic step(input string nm, input logic use_tab, input logic [2:0] x_rg, input logic [1:0] x_wg);
    int g, w, s, ws;
    logic [2:0] eg;
    logic [1:0] ew;
    logic [15:0] nd;
    #4;
    g = -1;
    for (int k = 0; k < 3; k++) begin
      int idx;
      idx = (m_ptr + k) % 3;
      if (g < 0 && rd_req[idx] && (m_lock < 0 || !rd_req[m_lock] || idx == m_lock)) g = idx;
    end
    w = -1;
    for (int i = 1; i >= 0; i--) if (wr_req[i]) w = i;
    eg = (g < 0) ? 3'b000 : 3'(1 << g);
    ew = (w < 0) ? 2'b00 : 2'(1 << w);
    s  = (g < 0) ? 0 : int'(rd_seg[2*g +: 2]);
    ws = (w < 0) ? 0 : int'(wr_seg[2*w +: 2]);
    chk({nm, ".rd_gnt"}, 32'(rd_gnt), 32'(eg));
    chk({nm, ".rf_rd_sel"}, 32'(rf_rd_sel), 32'(s));
    chk({nm, ".wr_gnt"}, 32'(wr_gnt), 32'(ew));
    chk({nm, ".rf_wr_en"}, 32'(rf_wr_en), 32'(w >= 0));
    if (w >= 0) begin
      chk({nm, ".rf_wr_sel"}, 32'(rf_wr_sel), 32'(ws));
      chk({nm, ".rf_wr_val"}, 32'(rf_wr_val), 32'(wr_data[16*w +: 16]));
    end
    if (use_tab) begin
      chk({nm, ".tab_rd_gnt"}, 32'(rd_gnt), 32'(x_rg));
      chk({nm, ".tab_wr_gnt"}, 32'(wr_gnt), 32'(x_wg));
    end
    nd = (w >= 0 && ws == s) ? wr_data[16*w +: 16] : shadow[s];
    @(posedge clk);
    if (g >= 0) begin
      m_ptr  = (g + 1) % 3;
      m_lock = rd_lock[g] ? g : -1;
    end else m_lock = -1;
    if (w >= 0) shadow[ws] = wr_data[16*w +: 16];
    exp_vld  = eg;
    exp_data = nd;
    exp_cs   = (w >= 0) && (ws == 1);
    #1;
    chk({nm, ".rd_valid"}, 32'(rd_valid), 32'(exp_vld));
    if (|exp_vld) chk({nm, ".rd_data"}, 32'(rd_data), 32'(exp_data));
    chk({nm, ".cs_changed"}, 32'(cs_changed), 32'(exp_cs));
  endtask

  typedef struct {
    logic [2:0]  rd_req, rd_lock;
    logic [5:0]  rd_seg;
    logic [1:0]  wr_req;
    logic [3:0]  wr_seg;
    logic [31:0] wr_data;
    logic [2:0]  x_rg;
    logic [1:0]  x_wg;
  } vec_t;
  vec_t vecs [17];

  initial begin
    // init writes, rotation, same-cycle bypass, write priority + CS pulse, ES readback, idle
    vecs[0]  = '{3'b000, 3'b000, 6'h00, 2'b01, 4'b0000, 32'h0000_0000, 3'b000, 2'b01};
    vecs[1]  = '{3'b000, 3'b000, 6'h00, 2'b01, 4'b0001, 32'h0000_1111, 3'b000, 2'b01};
    vecs[2]  = '{3'b000, 3'b000, 6'h00, 2'b10, 4'b1000, 32'h2222_0000, 3'b000, 2'b10};
    vecs[3]  = '{3'b000, 3'b000, 6'h00, 2'b11, 4'b1111, 32'h9999_3333, 3'b000, 2'b01};
    vecs[4]  = '{3'b111, 3'b000, 6'b110100, 2'b00, 4'b0000, 32'h0, 3'b001, 2'b00};
    vecs[5]  = '{3'b111, 3'b000, 6'b110100, 2'b00, 4'b0000, 32'h0, 3'b010, 2'b00};
    vecs[6]  = '{3'b111, 3'b000, 6'b110100, 2'b00, 4'b0000, 32'h0, 3'b100, 2'b00};
    vecs[7]  = '{3'b111, 3'b000, 6'b110100, 2'b00, 4'b0000, 32'h0, 3'b001, 2'b00};
    vecs[8]  = '{3'b010, 3'b000, 6'b001100, 2'b01, 4'b0011, 32'h0000_1234, 3'b010, 2'b01};
    vecs[9]  = '{3'b000, 3'b000, 6'h00, 2'b11, 4'b0001, 32'h0042_F000, 3'b000, 2'b01};
    vecs[10] = '{3'b000, 3'b000, 6'h00, 2'b10, 4'b0001, 32'h0042_F000, 3'b000, 2'b10};
    vecs[11] = '{3'b100, 3'b000, 6'b000000, 2'b00, 4'b0000, 32'h0, 3'b100, 2'b00};
    for (int i = 12; i < 17; i++) vecs[i] = '{3'b000, 3'b000, 6'h00, 2'b00, 4'b0000, 32'h0, 3'b000, 2'b00};
    for (int i = 0; i < 4; i++) shadow[i] = 16'h0;

    reset = 1'b1;
    rd_req = 3'b111; rd_lock = 3'b000; rd_seg = 6'h0;
    wr_req = 2'b11; wr_seg = 4'h0; wr_data = 32'h0;
    #2;
    chk("rst.rd_gnt", 32'(rd_gnt), 32'h0);
    chk("rst.wr_gnt", 32'(wr_gnt), 32'h0);
    chk("rst.rf_wr_en", 32'(rf_wr_en), 32'h0);
    repeat (2) @(posedge clk);
    chk("rst.rd_valid", 32'(rd_valid), 32'h0);
    chk("rst.cs_changed", 32'(cs_changed), 32'h0);
    #1 reset = 1'b0;

    for (int i = 0; i < 17; i++) begin
      rd_req = vecs[i].rd_req; rd_lock = vecs[i].rd_lock; rd_seg = vecs[i].rd_seg;
      wr_req = vecs[i].wr_req; wr_seg = vecs[i].wr_seg; wr_data = vecs[i].wr_data;
      step($sformatf("vec%0d", i), 1'b1, vecs[i].x_rg, vecs[i].x_wg);
    end

    // Debug lock: three back-to-back debug grants, then EU.
    wr_req = 2'b00; rd_seg = 6'b100100;
    rd_req = 3'b100; rd_lock = 3'b100; step("lock0", 1'b1, 3'b100, 2'b00);
    rd_req = 3'b111; rd_lock = 3'b100; step("lock1", 1'b1, 3'b100, 2'b00);
    rd_req = 3'b111; rd_lock = 3'b000; step("lock2", 1'b1, 3'b100, 2'b00);
    rd_req = 3'b111; rd_lock = 3'b000; step("lock3", 1'b1, 3'b001, 2'b00);

    // Reset right after a BIU grant drops the valid and returns the pointer to EU.
    step("prerst", 1'b1, 3'b010, 2'b00);
    reset = 1'b1;
    #1;
    chk("midrst.rd_valid", 32'(rd_valid), 32'h0);
    chk("midrst.rd_gnt", 32'(rd_gnt), 32'h0);
    @(posedge clk);
    #1 reset = 1'b0;
    m_ptr = 0; m_lock = -1;
    step("postrst", 1'b1, 3'b001, 2'b00);

    for (int c = 0; c < 400; c++) begin
      rd_req  = 3'($urandom_range(0, 7));
      rd_lock = ($urandom_range(0, 2) == 0) ? 3'($urandom_range(0, 7)) : 3'b000;
      rd_seg  = 6'($urandom);
      wr_req  = 2'($urandom_range(0, 3));
      wr_seg  = 4'($urandom);
      wr_data = $urandom;
      step("rand", 1'b0, 3'b000, 2'b00);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
